// File: rtl/definitions.sv
// Shared instruction encodings used by the control decoder and the sequencer.
// cCALL / cRET are the {opcode, fcode} patterns that select the return-stack
// behaviour of an absolute branch.
package definitions;

  localparam logic [4:0] cCALL = 5'b1110_0;
  localparam logic [4:0] cRET  = 5'b1110_1;

endpackage

// File: rtl/pc_sequencer_if.sv
// Sequencer <-> ROM/decoder bus.
//   imem_addr/imem_data : instruction ROM fetch (data is combinational from addr)
//   opcode/fcode/operand: instruction fields presented to the decoder
//   DONE                : squash indication to the decoder
//   CTRL_* / zero_flag  : branch controls and datapath zero result from decoder
//   rel_offset          : signed relative branch offset
//   abs_target          : absolute target for J/CALL
// master = sequencer side, slave = ROM/decoder side.
interface pc_sequencer_if #(
  parameter int unsigned PC_W    = 10,
  parameter int unsigned INSTR_W = 9
);

  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [3:0]         opcode;
  logic               fcode;
  logic [3:0]         operand;
  logic               DONE;
  logic               CTRL_branch_rel_z;
  logic               CTRL_branch_rel_nz;
  logic               CTRL_branch_abs;
  logic               zero_flag;
  logic [PC_W-1:0]    rel_offset;
  logic [PC_W-1:0]    abs_target;

  modport master (
    output imem_addr, opcode, fcode, operand, DONE,
    input  imem_data, CTRL_branch_rel_z, CTRL_branch_rel_nz, CTRL_branch_abs,
           zero_flag, rel_offset, abs_target
  );

  modport slave (
    input  imem_addr, opcode, fcode, operand, DONE,
    output imem_data, CTRL_branch_rel_z, CTRL_branch_rel_nz, CTRL_branch_abs,
           zero_flag, rel_offset, abs_target
  );

endinterface

// File: rtl/pc_sequencer.sv
// Instruction sequencer: holds the PC, fetches from the instruction ROM,
// splits the word into decoder fields, raises DONE to squash the decoder
// when idle/halted/faulting, and applies branch controls (including a
// CALL/RET return stack) to form the next PC.
// Ports:
//   CLK, RST_N  : clock, asynchronous active-low reset
//   START       : begin/restart execution from IDLE or HALTED
//   bus         : ROM fetch + decoder interface (master side)
//   stack_err   : sticky return-stack overflow/underflow
//   instr_count : saturating retired-instruction counter
module pc_sequencer #(
  parameter int unsigned        PC_W        = 10,
  parameter int unsigned        INSTR_W     = 9,
  parameter logic [PC_W-1:0]    START_ADDR  = '0,
  parameter int unsigned        STACK_DEPTH = 4,
  parameter logic [INSTR_W-1:0] HALT_INSTR  = 9'h1FF
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  pc_sequencer_if.master        bus,
  output logic                  stack_err,
  output logic [15:0]           instr_count
);

  import definitions::*;

  localparam int unsigned SP_W = $clog2(STACK_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] stack [STACK_DEPTH];
  logic [SP_W:0]   sp;
  logic [SP_W-1:0] top_idx;
  logic [4:0]      op_f;
  logic            is_halt;
  logic            is_call;
  logic            is_ret;
  logic            fault;
  logic            push;
  logic            pop;

  always_comb begin
    op_f    = bus.imem_data[8:4];
    is_halt = (bus.imem_data == HALT_INSTR);
    is_call = bus.CTRL_branch_abs && (op_f == cCALL);
    is_ret  = bus.CTRL_branch_abs && (op_f == cRET);
    top_idx = SP_W'(sp - (SP_W+1)'(1));
    pc_inc  = pc + PC_W'(1);
    // Halt wins over any stack action; a fault only exists while running.
    fault   = (state == RUN) && !is_halt &&
              ((is_call && (sp == (SP_W+1)'(STACK_DEPTH))) ||
               (is_ret  && (sp == '0)));
    push    = 1'b0;
    pop     = 1'b0;
    if (is_call) begin
      push    = 1'b1;
      pc_next = bus.abs_target;
    end else if (is_ret) begin
      pop     = 1'b1;
      pc_next = stack[top_idx];
    end else if (bus.CTRL_branch_abs) begin
      pc_next = bus.abs_target;
    end else if ((bus.CTRL_branch_rel_z && bus.zero_flag) ||
                 (bus.CTRL_branch_rel_nz && !bus.zero_flag)) begin
      // Equal widths: the add wraps modulo 2^PC_W, which is exactly the
      // sign-extended offset added with wrap.
      pc_next = pc + bus.rel_offset;
    end else begin
      pc_next = pc_inc;
    end
  end

  assign bus.imem_addr = pc;
  assign bus.opcode    = bus.imem_data[8:5];
  assign bus.fcode     = bus.imem_data[4];
  assign bus.operand   = bus.imem_data[3:0];
  assign bus.DONE      = (state != RUN) || is_halt || fault;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      pc          <= '0;
      sp          <= '0;
      stack_err   <= 1'b0;
      instr_count <= '0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
        stack[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE, HALTED: begin
          if (START) begin
            state       <= RUN;
            pc          <= START_ADDR;
            sp          <= '0;
            stack_err   <= 1'b0;
            instr_count <= '0;
          end
        end
        RUN: begin
          if (is_halt) begin
            state <= HALTED;
          end else if (fault) begin
            stack_err <= 1'b1;
            state     <= HALTED;
          end else begin
            pc <= pc_next;
            if (instr_count != '1) begin
              instr_count <= instr_count + 16'd1;
            end
            if (push) begin
              stack[sp[SP_W-1:0]] <= pc_inc;
              sp                  <= sp + (SP_W+1)'(1);
            end
            if (pop) begin
              sp <= sp - (SP_W+1)'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random
// programs, compared against a behavioural model (integer PC, queue stack).
module tb_pc_sequencer;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 9;
  localparam int DEPTH   = 4;

  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_BEQZ = 4'h2;
  localparam logic [3:0] OP_BNEZ = 4'h3;
  localparam logic [3:0] OP_J    = 4'h4;
  localparam logic [3:0] OP_CR   = 4'hE;  // fcode 0 = CALL, 1 = RET
  localparam logic [8:0] W_HALT  = 9'h1FF;

  logic        CLK   = 1'b0;
  logic        RST_N = 1'b1;
  logic        START = 1'b0;
  logic        zf    = 1'b0;
  logic        stack_err;
  logic [15:0] instr_count;

  logic [8:0] rom  [1024];
  logic [9:0] offs [1024];
  logic [9:0] targ [1024];

  int n_cmp = 0;
  int n_err = 0;

  // Model state: 0 idle, 1 run, 2 halted
  int m_state = 0;
  int m_pc    = 0;
  int m_stk[$];
  int m_err   = 0;
  int m_cnt   = 0;

  pc_sequencer_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  pc_sequencer #(
    .PC_W       (PC_W),
    .INSTR_W    (INSTR_W),
    .START_ADDR (10'd0),
    .STACK_DEPTH(DEPTH),
    .HALT_INSTR (9'h1FF)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .START      (START),
    .bus        (bus),
    .stack_err  (stack_err),
    .instr_count(instr_count)
  );

  always #5 CLK = ~CLK;

  // ROM and a minimal decoder driven from the fetched word
  assign bus.imem_data          = rom[bus.imem_addr];
  assign bus.CTRL_branch_abs    = (bus.imem_data[8:5] == OP_J) || (bus.imem_data[8:5] == OP_CR);
  assign bus.CTRL_branch_rel_z  = (bus.imem_data[8:5] == OP_BEQZ);
  assign bus.CTRL_branch_rel_nz = (bus.imem_data[8:5] == OP_BNEZ);
  assign bus.zero_flag          = zf;
  assign bus.rel_offset         = offs[bus.imem_addr];
  assign bus.abs_target         = targ[bus.imem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] mk(input logic [3:0] op, input logic f, input logic [3:0] opd);
    return {op, f, opd};
  endfunction

  task automatic clear_rom();
    for (int a = 0; a < 1024; a++) begin
      rom[a]  = mk(OP_ADDI, 1'b0, a[3:0]);
      offs[a] = '0;
      targ[a] = '0;
    end
  endtask

  // One clock: check combinational outputs for the current instruction,
  // advance the model across the edge, then check registered state.
  task automatic cycle(input bit st, input bit z);
    logic [8:0] w;
    bit halt, call, ret, jmp, bz, bnz, flt, dexp;
    int off;
    START = st;
    zf    = z;
    #1;
    w    = rom[m_pc];
    halt = (w == W_HALT);
    call = (w[8:5] == OP_CR) && !w[4];
    ret  = (w[8:5] == OP_CR) && w[4];
    jmp  = (w[8:5] == OP_J);
    bz   = (w[8:5] == OP_BEQZ);
    bnz  = (w[8:5] == OP_BNEZ);
    flt  = (m_state == 1) && !halt &&
           ((call && m_stk.size() == DEPTH) || (ret && m_stk.size() == 0));
    dexp = (m_state != 1) || halt || flt;
    check("done", bus.DONE, dexp);
    check("opcode", bus.opcode, w[8:5]);
    check("fcode", bus.fcode, w[4]);
    check("operand", bus.operand, w[3:0]);
    @(posedge CLK);
    #1;
    if (m_state != 1) begin
      if (st) begin
        m_state = 1; m_pc = 0; m_stk.delete(); m_err = 0; m_cnt = 0;
      end
    end else if (halt) begin
      m_state = 2;
    end else if (flt) begin
      m_err = 1; m_state = 2;
    end else begin
      if (m_cnt < 65535) m_cnt++;
      if (call) begin
        m_stk.push_back((m_pc + 1) % 1024);
        m_pc = targ[m_pc];
      end else if (ret) begin
        m_pc = m_stk.pop_back();
      end else if (jmp) begin
        m_pc = targ[m_pc];
      end else if ((bz && z) || (bnz && !z)) begin
        off  = $signed(offs[m_pc]);
        m_pc = (m_pc + off + 1024) % 1024;
      end else begin
        m_pc = (m_pc + 1) % 1024;
      end
    end
    check("addr", bus.imem_addr, m_pc);
    check("stack_err", stack_err, m_err);
    check("count", instr_count, m_cnt);
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic do_reset();
    @(posedge CLK);
    #3;
    RST_N = 1'b0;
    START = 1'b0;
    #1;
    check("rst_done", bus.DONE, 1);
    check("rst_addr", bus.imem_addr, 0);
    check("rst_count", instr_count, 0);
    check("rst_err", stack_err, 0);
    #1;
    RST_N   = 1'b1;
    m_state = 0; m_pc = 0; m_stk.delete(); m_err = 0; m_cnt = 0;
    @(posedge CLK);
    #1;
  endtask

  task automatic run_until(input int addr, input int budget);
    int k = 0;
    while (m_pc != addr && k < budget) begin
      cycle(1'b0, 1'($urandom_range(0, 1)));
      k++;
    end
    check("reach_addr", bus.imem_addr, addr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    clear_rom();

    // Straight-line program with halt at 5
    rom[5] = W_HALT;
    do_reset();
    cycle(1'b1, 1'b0);
    run_until(5, 10);
    cycle(1'b0, 1'b0);
    check("halt_addr", bus.imem_addr, 5);
    check("halt_count", instr_count, 5);
    cycle(1'b0, 1'b0);
    check("halted_done", bus.DONE, 1);

    // BEQZ at 3 with offset -2, taken then not taken
    clear_rom();
    rom[3]  = mk(OP_BEQZ, 1'b0, 4'h0);
    offs[3] = 10'h3FE;
    do_reset();
    cycle(1'b1, 1'b0);
    run_until(3, 10);
    cycle(1'b0, 1'b1);
    check("beqz_taken", bus.imem_addr, 1);
    do_reset();
    cycle(1'b1, 1'b0);
    run_until(3, 10);
    cycle(1'b0, 1'b0);
    check("beqz_fall", bus.imem_addr, 4);

    // CALL 2->40, RET 40->3, then RET on the now-empty stack at 3
    clear_rom();
    rom[2]  = mk(OP_CR, 1'b0, 4'h0);
    targ[2] = 10'd40;
    rom[40] = mk(OP_CR, 1'b1, 4'h0);
    rom[3]  = mk(OP_CR, 1'b1, 4'h0);
    do_reset();
    cycle(1'b1, 1'b0);
    run_until(2, 10);
    cycle(1'b0, 1'b0);
    check("call_target", bus.imem_addr, 40);
    cycle(1'b0, 1'b0);
    check("ret_addr", bus.imem_addr, 3);
    START = 1'b0;
    #1;
    check("uflow_done", bus.DONE, 1);
    cycle(1'b0, 1'b0);
    check("uflow_err", stack_err, 1);
    check("uflow_hold", bus.imem_addr, 3);
    check("uflow_count", instr_count, 4);

    // Five nested CALLs overflow a 4-deep stack
    clear_rom();
    for (int i = 0; i < 5; i++) begin
      rom[i * 10]  = mk(OP_CR, 1'b0, 4'h0);
      targ[i * 10] = 10'((i + 1) * 10);
    end
    do_reset();
    cycle(1'b1, 1'b0);
    run_until(40, 10);
    START = 1'b0;
    #1;
    check("ovf_done", bus.DONE, 1);
    cycle(1'b0, 1'b0);
    check("ovf_err", stack_err, 1);
    check("ovf_hold", bus.imem_addr, 40);
    cycle(1'b1, 1'b0);
    check("restart_err", stack_err, 0);
    check("restart_addr", bus.imem_addr, 0);

    // PC wrap: jump to 3FF, then a plain instruction wraps to 0
    clear_rom();
    rom[0]  = mk(OP_J, 1'b0, 4'h0);
    targ[0] = 10'h3FF;
    do_reset();
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    check("jump_3ff", bus.imem_addr, 10'h3FF);
    cycle(1'b0, 1'b0);
    check("wrap", bus.imem_addr, 0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    // Mid-run asynchronous reset (checks inside do_reset)
    do_reset();

    // Random programs
    for (int t = 0; t < 15; t++) begin
      for (int a = 0; a < 1024; a++) begin
        r = $urandom_range(0, 99);
        if (r < 50)      rom[a] = mk(OP_ADDI, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        else if (r < 60) rom[a] = mk(OP_BEQZ, 1'b0, 4'h0);
        else if (r < 70) rom[a] = mk(OP_BNEZ, 1'b0, 4'h0);
        else if (r < 78) rom[a] = mk(OP_J, 1'b0, 4'h0);
        else if (r < 87) rom[a] = mk(OP_CR, 1'b0, 4'h0);
        else if (r < 96) rom[a] = mk(OP_CR, 1'b1, 4'h0);
        else             rom[a] = W_HALT;
        offs[a] = 10'($urandom_range(0, 15)) - 10'd8;
        targ[a] = 10'($urandom_range(0, 1023));
      end
      do_reset();
      for (int c = 0; c < 300; c++) begin
        if ($urandom_range(0, 199) == 0) do_reset();
        cycle(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
